// File: rtl/full_handshake_rx.sv
// Receive end of a four-phase cross-clock-domain handshake: synchronizes the TX request,
// captures the qualified data word, strobes it to local logic and returns the acknowledge.
`timescale 1ns/1ps

module full_handshake_rx #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_i,
  input  logic [DW-1:0] req_data_i,
  output logic          ack_o,
  output logic          recv_rdy_o,
  output logic [DW-1:0] recv_data_o,
  output logic          idle_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'b001,
    ASSERT   = 3'b010,
    DEASSERT = 3'b100
  } state_t;

  state_t        state, state_n;
  logic          req_d, req;
  logic          ack_n, rdy_n, idle_n;
  logic [DW-1:0] data_n;

  // NOTE: req_i is asynchronous to clk; only the second flop may feed logic, the first
  // one is allowed to go metastable. req_data_i needs no synchronizer because it is
  // only sampled once req has been high for two edges, long after the bus settled.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_d <= 1'b0;
      req   <= 1'b0;
    end else begin
      req_d <= req_i;
      req   <= req_d;
    end
  end

  // NOTE: state and outputs update with non-blocking assignments so every flop samples
  // pre-edge values; blocking here would let ordering between blocks change behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ack_o       <= 1'b0;
      recv_rdy_o  <= 1'b0;
      recv_data_o <= '0;
      idle_o      <= 1'b1;
    end else begin
      state       <= state_n;
      ack_o       <= ack_n;
      recv_rdy_o  <= rdy_n;
      recv_data_o <= data_n;
      idle_o      <= idle_n;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    ack_n   = ack_o;
    rdy_n   = 1'b0;
    idle_n  = idle_o;
    data_n  = recv_data_o;
    case (state)
      IDLE: begin
        if (req) begin
          state_n = ASSERT;
          ack_n   = 1'b1;
          rdy_n   = 1'b1;
          idle_n  = 1'b0;
          data_n  = req_data_i;
        end
      end
      ASSERT: begin
        if (!req) begin
          state_n = DEASSERT;
          ack_n   = 1'b0;
        end
      end
      DEASSERT: begin
        state_n = IDLE;
        idle_n  = 1'b1;
      end
      default: begin
        // Corrupted one-hot code: recover to a clean idle, keep the last delivered word.
        state_n = IDLE;
        ack_n   = 1'b0;
        idle_n  = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_full_handshake_rx.sv
// Self-checking bench for full_handshake_rx: directed latency/boundary cases in the RX clock
// plus randomized four-phase bursts from a TX-side model in an unrelated clock.
`timescale 1ns/1ps

module tb_full_handshake_rx;
  localparam int DW      = 32;
  localparam int RX_HALF = 15;

  logic          clk    = 1'b0;
  logic          tx_clk = 1'b0;
  logic          rst;
  logic          req_i;
  logic [DW-1:0] req_data_i;
  logic          ack_o;
  logic          recv_rdy_o;
  logic [DW-1:0] recv_data_o;
  logic          idle_o;

  int tx_half = 15;
  int checks  = 0;
  int errors  = 0;
  int strobes = 0;

  logic [DW-1:0] sb[$];
  logic          ack_s1 = 1'b0;
  logic          ack_s2 = 1'b0;

  full_handshake_rx #(.DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .req_data_i (req_data_i),
    .ack_o      (ack_o),
    .recv_rdy_o (recv_rdy_o),
    .recv_data_o(recv_data_o),
    .idle_o     (idle_o)
  );

  always #RX_HALF clk = ~clk;

  // TX clock starts off-phase so its edges never coincide with RX edges for any ratio used.
  initial begin
    #7;
    forever begin
      #(tx_half);
      tx_clk = ~tx_clk;
    end
  end

  // TX-side synchronizer for the acknowledge.
  always @(posedge tx_clk) begin
    ack_s1 <= ack_o;
    ack_s2 <= ack_s1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expected word.
  always @(negedge clk) begin
    if (recv_rdy_o === 1'b1) begin
      strobes++;
      if (sb.size() == 0)
        check("strobe_expected", 64'(sb.size() != 0), 64'd1);
      else
        check("recv_data", 64'(recv_data_o), 64'(sb.pop_front()));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic rx_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ack_rx(input logic lvl, input string name);
    int n = 0;
    while (ack_o !== lvl && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(ack_o), 64'(lvl));
  endtask

  task automatic wait_idle_rx(input string name);
    int n = 0;
    while (idle_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(idle_o), 64'd1);
  endtask

  task automatic rx_transfer(input logic [DW-1:0] d);
    req_data_i = d;
    req_i      = 1'b1;
    sb.push_back(d);
    wait_ack_rx(1'b1, "xfer_ack_high");
    req_i = 1'b0;
    wait_idle_rx("xfer_idle");
  endtask

  task automatic tx_send(input logic [DW-1:0] d);
    int n;
    @(negedge tx_clk);
    req_data_i = d;
    req_i      = 1'b1;
    sb.push_back(d);
    n = 0;
    while (ack_s2 !== 1'b1 && n < 200) begin
      @(negedge tx_clk);
      n++;
    end
    check("tx_ack_high", 64'(ack_s2), 64'd1);
    req_i = 1'b0;
    n = 0;
    while (ack_s2 !== 1'b0 && n < 200) begin
      @(negedge tx_clk);
      n++;
    end
    check("tx_ack_low", 64'(ack_s2), 64'd0);
  endtask

  task automatic run_burst(input int half, input string tag, input bit rand_data, input int count);
    int            base;
    int            n;
    logic [DW-1:0] d;
    tx_half = half;
    base    = strobes;
    for (int i = 1; i <= count; i++) begin
      d = rand_data ? DW'($urandom()) : DW'(i);
      tx_send(d);
      repeat ($urandom_range(0, 3)) @(negedge tx_clk);
    end
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain"}, 64'(sb.size()), 64'd0);
    rx_cycles(4);
    check({tag, "_strobes"}, 64'(strobes - base), 64'(count));
  endtask

  initial begin
    int base;

    // Reset with a request already pending: reset must dominate.
    rst        = 1'b1;
    req_i      = 1'b1;
    req_data_i = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_ack", 64'(ack_o), 64'd0);
      check("reset_rdy", 64'(recv_rdy_o), 64'd0);
      check("reset_data", 64'(recv_data_o), 64'd0);
      check("reset_idle", 64'(idle_o), 64'd1);
    end
    req_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rx_cycles(3);
    check("post_reset_idle", 64'(idle_o), 64'd1);
    check("post_reset_ack", 64'(ack_o), 64'd0);

    // Single transfer, cycle-exact latency.
    req_data_i = 32'hDEAD_BEEF;
    req_i      = 1'b1;
    sb.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    check("lat_e0_ack", 64'(ack_o), 64'd0);
    check("lat_e0_idle", 64'(idle_o), 64'd1);
    @(negedge clk);
    check("lat_e1_ack", 64'(ack_o), 64'd0);
    check("lat_e1_rdy", 64'(recv_rdy_o), 64'd0);
    @(negedge clk);
    check("lat_e2_ack", 64'(ack_o), 64'd1);
    check("lat_e2_rdy", 64'(recv_rdy_o), 64'd1);
    check("lat_e2_data", 64'(recv_data_o), 64'hDEAD_BEEF);
    check("lat_e2_idle", 64'(idle_o), 64'd0);
    @(negedge clk);
    check("lat_e3_rdy", 64'(recv_rdy_o), 64'd0);
    check("lat_e3_ack", 64'(ack_o), 64'd1);
    rx_cycles(2);
    req_i = 1'b0;
    @(negedge clk);
    check("lat_f0_ack", 64'(ack_o), 64'd1);
    @(negedge clk);
    check("lat_f1_ack", 64'(ack_o), 64'd1);
    @(negedge clk);
    check("lat_f2_ack", 64'(ack_o), 64'd0);
    check("lat_f2_idle", 64'(idle_o), 64'd0);
    @(negedge clk);
    check("lat_f3_idle", 64'(idle_o), 64'd1);
    rx_cycles(4);

    // Received word holds while the bus changes with no request.
    rx_transfer(32'h5A5A_5A5A);
    req_data_i = 32'h1234_5678;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("hold_data", 64'(recv_data_o), 64'h5A5A_5A5A);
      check("hold_rdy", 64'(recv_rdy_o), 64'd0);
    end

    // Reset mid-transfer with request still high: duplicate delivery expected.
    req_data_i = 32'h0000_00A5;
    req_i      = 1'b1;
    sb.push_back(32'h0000_00A5);
    sb.push_back(32'h0000_00A5);
    wait_ack_rx(1'b1, "mid_ack_high");
    rx_cycles(2);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ack", 64'(ack_o), 64'd0);
    check("mid_rst_rdy", 64'(recv_rdy_o), 64'd0);
    check("mid_rst_idle", 64'(idle_o), 64'd1);
    check("mid_rst_data", 64'(recv_data_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_r1_ack", 64'(ack_o), 64'd0);
    @(negedge clk);
    check("mid_r2_ack", 64'(ack_o), 64'd0);
    @(negedge clk);
    check("mid_r3_ack", 64'(ack_o), 64'd1);
    check("mid_r3_rdy", 64'(recv_rdy_o), 64'd1);
    req_i = 1'b0;
    wait_idle_rx("mid_idle");
    rx_cycles(4);

    // Stuck request: single strobe, acknowledge held.
    base       = strobes;
    req_data_i = DW'($urandom());
    sb.push_back(req_data_i);
    req_i = 1'b1;
    rx_cycles(100);
    check("stuck_ack", 64'(ack_o), 64'd1);
    check("stuck_idle", 64'(idle_o), 64'd0);
    check("stuck_strobes", 64'(strobes - base), 64'd1);
    req_i = 1'b0;
    wait_idle_rx("stuck_idle_after");
    rx_cycles(4);

    // Back-to-back bursts from an unrelated TX clock at several ratios.
    run_burst(15, "ratio_1_1", 1'b0, 256);
    run_burst(45, "ratio_3_1", 1'b0, 256);
    run_burst(5,  "ratio_1_3", 1'b0, 256);
    run_burst(15, "random_data", 1'b1, 32);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/full_handshake_rx.md
Name: full_handshake_rx

Overview:
Receive end of the four-phase (full) cross-clock-domain handshake.
- Synchronizes the incoming request from the TX clock domain.
- Captures the accompanying data word and presents it to local logic as a one-cycle strobe.
- Drives the acknowledge back to the TX end through the sequence req=1 -> ack=1 -> req=0 -> ack=0.
- Sits in the RX clock domain, paired with the transmit-side handshake block, for slow control/data transfers such as debug and peripheral bridges.

Parameters:
DW, 32, width of the transferred data word

Ports:
clk  input  1  RX-domain clock
rst  input  1  synchronous reset, active-high
req_i  input  1  request from TX end (asynchronous to clk)
req_data_i  input  DW  data from TX end; stable while req_i=1 (asynchronous bus, qualified by req_i)
ack_o  output  1  acknowledge to TX end; registered
recv_rdy_o  output  1  one-cycle strobe: recv_data_o holds a new word
recv_data_o  output  DW  last received data word; registered
idle_o  output  1  1 when no transfer is in progress on the RX side

Behaviour:

Reset (rst=1 at a rising edge of clk):
- ack_o=0, recv_rdy_o=0, recv_data_o=0, idle_o=1.
- Both synchronizer flops=0; state=IDLE.

Synchronizer:
- req_i passes through two flops (req_d, then req).
- Only req (the second stage) is used by the FSM.
- req_data_i is never synchronized. It is sampled only when req=1, which guarantees at least two clk edges of stability.

FSM, one-hot, three states:
- IDLE: if req=1 -> ASSERT.
  - On that same edge: ack_o<=1, recv_data_o<=req_data_i, recv_rdy_o<=1, idle_o<=0.
  - Otherwise remain in IDLE.
- ASSERT: wait for req=0.
  - If req=1: hold; ack_o stays 1.
  - If req=0: ack_o<=0, go to DEASSERT.
- DEASSERT: one settling cycle. idle_o<=1, then go to IDLE.
  - A new request cannot be seen before this cycle: TX must first observe ack=0 through its own two-flop synchronizer, then raise req again.
- Illegal or unreachable state codes -> IDLE, with outputs as in reset except recv_data_o, which holds.

Output rules:
- recv_rdy_o is 1 for exactly one cycle per transfer, on the cycle after the FSM leaves IDLE.
- recv_data_o holds its value until the next transfer; it is not cleared after the strobe.

Latency:
- req_i rising, first sampled high at edge E0: req_d=1 after E0, req=1 after E1.
- At E2: ack_o=1 and recv_rdy_o=1 with captured data.
- At E3: recv_rdy_o=0.
- req_i falling, first sampled low at edge F0: ack_o=0 after F2; idle_o=1 after F3.

Boundary conditions:
- req_i glitch shorter than one clk period that is not captured by req_d: no effect.
- req_i high for exactly one sampled edge and captured: the transfer completes normally (the protocol forbids this; no error flag).
- req_i stuck high: remain in ASSERT with ack_o=1 indefinitely; no further strobes.
- Reset mid-transfer: ack_o drops on the reset edge and the FSM restarts in IDLE.
  - If TX still holds req=1, the word is re-accepted after two edges and a second strobe is issued. Duplicate delivery on reset is the defined behaviour.
- rst and req_i asserted together: reset wins; the synchronizer clears.
- Back-to-back transfers: minimum period is bounded by the two synchronizers on each side. No queuing; one word in flight.

Test Plan:
1. Reset: hold rst=1 for 3 cycles with req_i=1 -> ack_o=0, recv_rdy_o=0, recv_data_o=0, idle_o=1 throughout.
2. Single transfer, DW=32: req_i=1 with req_data_i=0xDEADBEEF sampled at E0 -> at E2 ack_o=1, recv_rdy_o=1, recv_data_o=0xDEADBEEF. At E3 recv_rdy_o=0. Drop req_i at F0 -> ack_o=0 after F2, idle_o=1 after F3.
3. Back-to-back with the transmit-side block in a second, unrelated clock (clock ratios 1:1, 3:1, 1:3): send 0x1, 0x2, ..., 0x100 -> exactly 256 strobes, in order, with no loss or duplicates.
4. Data held after strobe: after receiving 0x5A5A5A5A, change req_data_i to 0x12345678 with req_i=0 -> recv_data_o stays 0x5A5A5A5A and recv_rdy_o stays 0.
5. Reset mid-transfer: assert rst for 1 cycle while in ASSERT with req_i=1, data=0xA5 -> ack_o=0 on the next cycle, then re-accepts (second strobe, recv_data_o=0xA5) two edges after rst is released.
6. Stuck request: hold req_i=1 for 100 cycles -> ack_o=1 and exactly one recv_rdy_o pulse.
